// File: rtl/rgb_compress_pkg.sv
// Shared constants for the RGB 3-bit compressor.
package rgb_compress_pkg;

  localparam int NUM_CHANNELS = 3;

  // Channel indices; B occupies the least significant field of the pixel.
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  // Midpoint of the clamp range, rounded up, used as the per-channel decision level.
  function automatic int threshold(input int min_t, input int max_t);
    return (min_t + max_t + 1) / 2;
  endfunction

endpackage

// File: rtl/rgb_compress.sv
// Compresses a stream of RGB pixels to one bit per channel: each channel's
// moving average over the last AVERAGE_OVER pixels is clamped and compared
// against the midpoint of the clamp range.
module rgb_compress
  import rgb_compress_pkg::*;
#(
  parameter int COLOUR_DEPTH = 8,
  parameter int AVERAGE_OVER = 3,
  parameter int MIN_THRES    = 0,
  parameter int MAX_THRES    = 255
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [3*COLOUR_DEPTH-1:0] rgb_in,
  output logic [2:0]                compressed_out
);

  localparam int SUM_W = COLOUR_DEPTH + $clog2(AVERAGE_OVER + 1);

  localparam logic [COLOUR_DEPTH-1:0] MIN_C = COLOUR_DEPTH'(MIN_THRES);
  localparam logic [COLOUR_DEPTH-1:0] MAX_C = COLOUR_DEPTH'(MAX_THRES);
  localparam logic [COLOUR_DEPTH-1:0] THR_C = COLOUR_DEPTH'(threshold(MIN_THRES, MAX_THRES));
  localparam logic [SUM_W-1:0]        DIV_C = SUM_W'(AVERAGE_OVER);

  // Top-level per-channel arrays, kept here so they show up by name in waveforms.
  logic [SUM_W-1:0]        colour_sum [0:NUM_CHANNELS-1];
  logic [COLOUR_DEPTH-1:0] colour_avg [0:NUM_CHANNELS-1];

  logic [NUM_CHANNELS-1:0] compressed_d;
  logic [2:0]              compressed_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [COLOUR_DEPTH-1:0] win_q [AVERAGE_OVER];
    logic [SUM_W-1:0]        sum_d;
    logic [COLOUR_DEPTH-1:0] avg_d;
    logic [COLOUR_DEPTH-1:0] clamp_d;

    // Shift window: newest sample enters slot 0, oldest falls off the end.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        for (int i = 0; i < AVERAGE_OVER; i++) begin
          win_q[i] <= '0;
        end
      end else begin
        win_q[0] <= rgb_in[c*COLOUR_DEPTH +: COLOUR_DEPTH];
        for (int i = 1; i < AVERAGE_OVER; i++) begin
          win_q[i] <= win_q[i-1];
        end
      end
    end

    // Exact window sum; SUM_W is wide enough that this never wraps.
    always_comb begin
      sum_d = '0;
      for (int i = 0; i < AVERAGE_OVER; i++) begin
        sum_d = sum_d + SUM_W'(win_q[i]);
      end
    end

    // Floor average by a constant divisor; the quotient always fits in one colour.
    assign avg_d = COLOUR_DEPTH'(sum_d / DIV_C);

    // Clamp the average into [MIN_THRES, MAX_THRES].
    always_comb begin
      clamp_d = avg_d;
      if (avg_d < MIN_C) begin
        clamp_d = MIN_C;
      end else if (avg_d > MAX_C) begin
        clamp_d = MAX_C;
      end
    end

    assign colour_sum[c]   = sum_d;
    assign colour_avg[c]   = avg_d;
    assign compressed_d[c] = (clamp_d >= THR_C);
  end

  // Registered decision bits: bit2 = R, bit1 = G, bit0 = B.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      compressed_q <= 3'b000;
    end else begin
      compressed_q <= compressed_d;
    end
  end

  assign compressed_out = compressed_q;

endmodule

// File: tb/tb_rgb_compress.sv
// Scoreboard bench for rgb_compress: a default instance and a clamped instance
// (MIN_THRES=64, MAX_THRES=127) share clock, reset and pixel stream.
module tb_rgb_compress;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb = 24'h0;
  logic [2:0]  out_a;
  logic [2:0]  out_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int       due;
    logic [2:0] e_a;
    logic [2:0] e_b;
  } exp_t;

  exp_t sb[$];
  int   hist[3][$];

  rgb_compress dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .rgb_in(rgb), .compressed_out(out_a)
  );

  rgb_compress #(
    .COLOUR_DEPTH(8), .AVERAGE_OVER(3), .MIN_THRES(64), .MAX_THRES(127)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .rgb_in(rgb), .compressed_out(out_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_sum_zero(input string name, input int act);
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL %s: got %0d expected 0", name, act);
    end
  endtask

  // Reference model: last three pixels per channel, plain integer averaging.
  task automatic reset_model();
    for (int c = 0; c < 3; c++) begin
      hist[c].delete();
      repeat (3) hist[c].push_back(0);
    end
  endtask

  function automatic logic [2:0] model(input int mn, input int mx);
    logic [2:0] r;
    r = 3'b000;
    for (int c = 0; c < 3; c++) begin
      int s;
      int a;
      s = 0;
      foreach (hist[c][i]) s += hist[c][i];
      a = s / 3;
      if (a < mn) a = mn;
      if (a > mx) a = mx;
      r[c] = (a >= (mn + mx + 1) / 2);
    end
    return r;
  endfunction

  // Called at a falling edge; sample enters at the next rising edge and is
  // visible on the output after the rising edge after that.
  task automatic drive(input logic [23:0] pix);
    exp_t e;
    rgb = pix;
    for (int c = 0; c < 3; c++) begin
      hist[c].push_front(int'((pix >> (8 * c)) & 24'hFF));
      void'(hist[c].pop_back());
    end
    e.due = cyc + 2;
    e.e_a = model(0, 255);
    e.e_b = model(64, 127);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    sb.delete();
    reset_model();
    #1;
    chk("rst_out_a", out_a, 3'b000);
    chk("rst_out_b", out_b, 3'b000);
    for (int c = 0; c < 3; c++) chk_sum_zero("rst_sum_a", int'(dut_a.colour_sum[c]));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_white();
    for (int j = 1; j <= 5; j++) begin
      drive(24'hFFFFFF);
      if (j == 2) chk("fill_edge2", out_a, 3'b000);
      if (j == 3) chk("fill_edge3", out_a, 3'b111);
      if (j == 4) chk("fill_edge4", out_a, 3'b111);
    end
  endtask

  task automatic steady(input logic [23:0] pix, input int n);
    for (int j = 0; j < n; j++) drive(pix);
  endtask

  // Monitor: pops expectations when their cycle comes due.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL sb_late: due %0d seen at cycle %0d", e.due, cyc);
      end else begin
        chk("sb_dut_a", out_a, e.e_a);
        chk("sb_dut_b", out_b, e.e_b);
      end
    end
  end

  initial begin
    reset_model();
    @(negedge clk);
    @(negedge clk);
    chk("init_out_a", out_a, 3'b000);
    chk("init_out_b", out_b, 3'b000);
    for (int c = 0; c < 3; c++) chk_sum_zero("init_sum_a", int'(dut_a.colour_sum[c]));
    rst_n = 1'b1;

    fill_white();

    steady(24'h808080, 4);
    chk("thr_128", out_a, 3'b111);
    steady(24'h7F7F7F, 4);
    chk("thr_127", out_a, 3'b000);

    steady(24'hFF0080, 4);
    chk("indep", out_a, 3'b101);

    drive(24'd100 << 16);
    drive(24'd100 << 16);
    drive(24'd200 << 16);
    drive(24'd100 << 16);
    chk("floor_133", {2'b00, out_a[2]}, 3'b001);
    drive(24'd100 << 16);
    drive(24'd183 << 16);
    drive(24'd0);
    chk("floor_127", {2'b00, out_a[2]}, 3'b000);

    steady(24'hFFFFFF, 4);
    do_reset();
    fill_white();

    steady(24'h505050, 4);
    chk("clamp_lo", out_b, 3'b000);
    steady(24'hFFFFFF, 4);
    chk("clamp_hi", out_b, 3'b111);

    for (int k = 0; k < 400; k++) begin
      logic [23:0] p;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 1) == 0) begin
        p = 24'($urandom);
      end else begin
        p = {8'($urandom_range(56, 136)), 8'($urandom_range(56, 136)), 8'($urandom_range(56, 136))};
      end
      drive(p);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
